butterfly_pipe: RTL

Pipelined, parametrised radix-2 DIT butterfly for the FFT datapath: out1 = in1 + in2·w, out2 = in1 − in2·w. All operands are signed two's-complement fixed point. The block adds a valid/ready stream handshake with backpressure, rounding, an optional per-stage divide-by-2 scaling mode, output saturation and a sticky overflow flag. It sits between the FFT memory/address sequencer and the twiddle ROM.

---
 rtl/butterfly_pipe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly: out1 = in1 + in2*w, out2 = in1 - in2*w,
// with valid/ready backpressure, half-up rounding, optional halving and saturation.
module butterfly_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = DATA_WIDTH / 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in1_r,
  input  logic signed [DATA_WIDTH-1:0] in1_i,
  input  logic signed [DATA_WIDTH-1:0] in2_r,
  input  logic signed [DATA_WIDTH-1:0] in2_i,
  input  logic signed [DATA_WIDTH-1:0] w_r,
  input  logic signed [DATA_WIDTH-1:0] w_i,
  input  logic                         scale,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out1_r,
  output logic signed [DATA_WIDTH-1:0] out1_i,
  output logic signed [DATA_WIDTH-1:0] out2_r,
  output logic signed [DATA_WIDTH-1:0] out2_i,
  output logic                         ovf,
  input  logic                         ovf_clr
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [PW:0] RND = (PW+1)'(1) << (FRAC_BITS - 1);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: full-width products
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [W-1:0]  a1_r_q, a1_i_q;
  logic                 sc1_q, v1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rr_q <= '0;
      p_ii_q <= '0;
      p_ri_q <= '0;
      p_ir_q <= '0;
      a1_r_q <= '0;
      a1_i_q <= '0;
      sc1_q  <= 1'b0;
      v1_q   <= 1'b0;
    end else if (adv) begin
      p_rr_q <= PW'(in2_r) * PW'(w_r);
      p_ii_q <= PW'(in2_i) * PW'(w_i);
      p_ri_q <= PW'(in2_r) * PW'(w_i);
      p_ir_q <= PW'(in2_i) * PW'(w_r);
      a1_r_q <= in1_r;
      a1_i_q <= in1_i;
      sc1_q  <= scale;
      v1_q   <= in_valid;
    end
  end

  // Stage 2: complex product, rounded half-up back to W+1 bits
  logic [PW:0]  tr_rnd, ti_rnd;
  logic [W:0]   t_r_d, t_i_d;
  logic [W:0]   t_r_q, t_i_q;
  logic signed [W-1:0] a2_r_q, a2_i_q;
  logic         sc2_q, v2_q;
  logic         unused_bits;

  always_comb begin
    tr_rnd = {p_rr_q[PW-1], p_rr_q} - {p_ii_q[PW-1], p_ii_q} + RND;
    ti_rnd = {p_ri_q[PW-1], p_ri_q} + {p_ir_q[PW-1], p_ir_q} + RND;
    // Slicing from FRAC_BITS up equals the arithmetic shift followed by truncation.
    t_r_d  = tr_rnd[FRAC_BITS+W:FRAC_BITS];
    t_i_d  = ti_rnd[FRAC_BITS+W:FRAC_BITS];
  end

  assign unused_bits = ^{tr_rnd[FRAC_BITS-1:0], tr_rnd[PW:FRAC_BITS+W+1],
                         ti_rnd[FRAC_BITS-1:0], ti_rnd[PW:FRAC_BITS+W+1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_r_q  <= '0;
      t_i_q  <= '0;
      a2_r_q <= '0;
      a2_i_q <= '0;
      sc2_q  <= 1'b0;
      v2_q   <= 1'b0;
    end else if (adv) begin
      t_r_q  <= t_r_d;
      t_i_q  <= t_i_d;
      a2_r_q <= a1_r_q;
      a2_i_q <= a1_i_q;
      sc2_q  <= sc1_q;
      v2_q   <= v1_q;
    end
  end

  // Returns {clipped, value}: optional half-up halving, then saturation to W bits.
  function automatic logic [W:0] scale_sat(input logic signed [W+1:0] s, input logic sc);
    logic signed [W+1:0] v;
    v = sc ? ((s + (W+2)'(1)) >>> 1) : s;
    if (v[W+1:W-1] == '0 || v[W+1:W-1] == '1)
      scale_sat = {1'b0, v[W-1:0]};
    else
      scale_sat = {1'b1, v[W+1], {(W-1){~v[W+1]}}};
  endfunction

  // Stage 3: sums, scaling, saturation
  logic signed [W+1:0] s1r, s1i, s2r, s2i;
  logic [W:0]          f1r, f1i, f2r, f2i;
  logic                clip;

  always_comb begin
    s1r  = {{2{a2_r_q[W-1]}}, a2_r_q} + {t_r_q[W], t_r_q};
    s1i  = {{2{a2_i_q[W-1]}}, a2_i_q} + {t_i_q[W], t_i_q};
    s2r  = {{2{a2_r_q[W-1]}}, a2_r_q} - {t_r_q[W], t_r_q};
    s2i  = {{2{a2_i_q[W-1]}}, a2_i_q} - {t_i_q[W], t_i_q};
    f1r  = scale_sat(s1r, sc2_q);
    f1i  = scale_sat(s1i, sc2_q);
    f2r  = scale_sat(s2r, sc2_q);
    f2i  = scale_sat(s2i, sc2_q);
    clip = f1r[W] | f1i[W] | f2r[W] | f2i[W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out1_r    <= '0;
      out1_i    <= '0;
      out2_r    <= '0;
      out2_i    <= '0;
    end else if (adv) begin
      out_valid <= v2_q;
      if (v2_q) begin
        out1_r <= f1r[W-1:0];
        out1_i <= f1i[W-1:0];
        out2_r <= f2r[W-1:0];
        out2_i <= f2i[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf <= 1'b0;
    else if (ovf_clr)
      ovf <= 1'b0;
    else if (adv && v2_q && clip)
      ovf <= 1'b1;
  end

endmodule
